// File: rtl/fetch_sender_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sender_pkg: shared constants and TX state encoding for fetch_sender
// Revision 1.0
// ============================================================================
package fetch_sender_pkg;

  localparam int          WORD_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } txState_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo: DEPTH x WORD_W synchronous FIFO with occupancy count and flush
// Revision 1.0
// ============================================================================
module fetch_fifo
  import fetch_sender_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wrData,
  output logic [WORD_W-1:0]        rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WORD_W-1:0] rMem [DEPTH];
  logic [PTR_W-1:0]  rWrPtr;
  logic [PTR_W-1:0]  rRdPtr;
  logic [CNT_W-1:0]  rCount;
  logic              wDoPop;
  logic              wFull;

  assign empty  = (rCount == '0);
  assign wFull  = (rCount == C_FULL);
  assign wDoPop = pop & ~empty;
  assign count  = rCount;
  assign rdData = rMem[rRdPtr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      rMem[rWrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else if (flush) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else begin
      if (push) begin
        rWrPtr <= rWrPtr + PTR_W'(1);
      end
      if (wDoPop) begin
        rRdPtr <= rRdPtr + PTR_W'(1);
      end
      case ({push, wDoPop})
        2'b10:   rCount <= rCount + CNT_W'(1);
        2'b01:   rCount <= rCount - CNT_W'(1);
        default: rCount <= rCount;
      endcase
    end
  end

  a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && wFull && !wDoPop));

endmodule
`default_nettype wire

// File: rtl/fetch_sender.sv
`default_nettype none
// ============================================================================
// fetch_sender: fetches words from instruction memory into a FIFO and sends
//               them downstream over a two-phase toggle handshake
// Revision 1.0
// ============================================================================
module fetch_sender
  import fetch_sender_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              branchValid,
  input  logic [WORD_W-1:0] branchTarget,
  output logic              imemReq,
  output logic [WORD_W-1:0] imemAddr,
  input  logic [WORD_W-1:0] imemData,
  input  logic              imemValid,
  output logic              readyOut,
  output logic [WORD_W-1:0] dataOut,
  output logic              triggerOut,
  input  logic              ackIn
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam int               ARM_N   = SYNC_STAGES + 1;
  localparam int               ARM_W   = $clog2(ARM_N + 1);
  localparam logic [ARM_W-1:0] C_ARM   = ARM_W'(ARM_N);

  logic [WORD_W-1:0]      rPc;
  logic                   rOutstanding;
  logic                   rStale;
  logic                   rStarted;
  logic                   wIssue;
  logic                   wPush;
  logic                   wPop;
  logic                   wEmpty;
  logic [CNT_W-1:0]       wCount;
  logic [WORD_W-1:0]      wHead;

  logic [SYNC_STAGES-1:0] rSync;
  logic                   rSyncPrev;
  logic [ARM_W-1:0]       rArmCnt;
  logic                   wSyncOut;
  logic                   wAckEdge;

  txState_t               rState;
  txState_t               wStateNext;
  logic                   wReadyNext;
  logic                   wTrigNext;
  logic [WORD_W-1:0]      wDataNext;

  // Credit check counts the in-flight word so a return can never overflow.
  assign wIssue   = rStarted & enable & ~branchValid & ~rOutstanding &
                    ((wCount + CNT_W'(rOutstanding)) < C_DEPTH);
  assign imemReq  = wIssue;
  assign imemAddr = wIssue ? rPc : '0;
  assign wPush    = imemValid & ~rStale & ~branchValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rPc          <= RESET_PC;
      rOutstanding <= 1'b0;
      rStale       <= 1'b0;
      rStarted     <= 1'b0;
    end else begin
      rStarted <= 1'b1;
      if (branchValid) begin
        rPc <= branchTarget & ~32'd3;
      end else if (wIssue) begin
        rPc <= rPc + PC_INC;
      end
      if (wIssue) begin
        rOutstanding <= 1'b1;
      end else if (imemValid) begin
        rOutstanding <= 1'b0;
      end
      if (imemValid) begin
        rStale <= 1'b0;
      end else if (branchValid && rOutstanding) begin
        rStale <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (branchValid),
    .push   (wPush),
    .pop    (wPop),
    .wrData (imemData),
    .rdData (wHead),
    .count  (wCount),
    .empty  (wEmpty)
  );

  // Edges are suppressed until the chain holds only post-reset samples of ackIn.
  assign wSyncOut = rSync[SYNC_STAGES-1];
  assign wAckEdge = (rArmCnt == C_ARM) & (wSyncOut ^ rSyncPrev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rSync     <= '0;
      rSyncPrev <= 1'b0;
      rArmCnt   <= '0;
    end else begin
      rSync     <= (rSync << 1) | SYNC_STAGES'(ackIn);
      rSyncPrev <= wSyncOut;
      if (rArmCnt != C_ARM) begin
        rArmCnt <= rArmCnt + ARM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState     <= ST_IDLE;
      readyOut   <= 1'b0;
      dataOut    <= '0;
      triggerOut <= 1'b0;
    end else begin
      rState     <= wStateNext;
      readyOut   <= wReadyNext;
      dataOut    <= wDataNext;
      triggerOut <= wTrigNext;
    end
  end

  always_comb begin
    wStateNext = rState;
    wReadyNext = readyOut;
    wDataNext  = dataOut;
    wTrigNext  = triggerOut;
    wPop       = 1'b0;
    case (rState)
      ST_IDLE: begin
        if (!wEmpty && !branchValid) begin
          wPop       = 1'b1;
          wDataNext  = wHead;
          wReadyNext = 1'b1;
          wStateNext = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // A redirect before the trigger edge withdraws the word entirely.
        if (branchValid) begin
          wReadyNext = 1'b0;
          wStateNext = ST_IDLE;
        end else begin
          wTrigNext  = ~triggerOut;
          wStateNext = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (wAckEdge) begin
          wReadyNext = 1'b0;
          wStateNext = ST_IDLE;
        end
      end
      default: begin
        wStateNext = ST_IDLE;
      end
    endcase
  end

  a_ackOnlyInWait: assert property (@(posedge clk) disable iff (!rst_n)
    wAckEdge |-> (rState == ST_WAIT_ACK));

endmodule
`default_nettype wire

// File: tb/tb_fetch_sender.sv
`default_nettype none
// ============================================================================
// tb_fetch_sender: randomized self-checking bench with a queue-based model
// Revision 1.0
// ============================================================================
module tb_fetch_sender;

  localparam int          DEPTH   = 4;
  localparam int          SYNC    = 2;
  localparam logic [31:0] MEM_OFS = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        branchValid = 1'b0;
  logic [31:0] branchTarget = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemData = '0;
  logic        imemValid = 1'b0;
  logic        readyOut;
  logic [31:0] dataOut;
  logic        triggerOut;
  logic        ackIn = 1'b0;

  fetch_sender #(
    .DEPTH       (DEPTH),
    .RESET_PC    (32'h0000_0000),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .branchValid  (branchValid),
    .branchTarget (branchTarget),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemData     (imemData),
    .imemValid    (imemValid),
    .readyOut     (readyOut),
    .dataOut      (dataOut),
    .triggerOut   (triggerOut),
    .ackIn        (ackIn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting, word on the wire, handshake phase.
  logic [31:0] mPc;
  bit          mOut;
  bit          mStale;
  logic [31:0] mQ[$];
  int          mPhase;   // 0 nothing offered, 1 offered not yet triggered, 2 triggered
  bit          mReady;
  logic [31:0] mData;
  bit          mTrig;
  bit          hist[$];  // ackIn level at each rising edge since reset release
  bit          reqNow;

  bit          pendRet;
  logic [31:0] pendData;
  int          ackCnt;
  int          ackDelay;
  bit          ackOn;
  bit          prevDutTrig;
  logic [31:0] reqLog[$];
  logic [31:0] sentLog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit modelAckEdge();
    int k = hist.size();
    if (k < SYNC + 1) return 1'b0;
    return hist[k-SYNC] != hist[k-SYNC-1];
  endfunction

  task automatic modelReset();
    mPc = 32'h0; mOut = 0; mStale = 0; mQ.delete();
    mPhase = 0; mReady = 0; mData = '0; mTrig = 0; hist.delete();
    pendRet = 0; pendData = '0; ackCnt = 0; prevDutTrig = 0;
    reqLog.delete(); sentLog.delete();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    branchValid = 1'b0;
    imemValid = 1'b0;
    #1;
    chk("rst imemReq", imemReq, 0);
    chk("rst imemAddr", imemAddr, 0);
    chk("rst readyOut", readyOut, 0);
    chk("rst dataOut", dataOut, 0);
    chk("rst triggerOut", triggerOut, 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive memory/ack, compare, advance model, wait for next negedge.
  task automatic step();
    bit edgeNow;
    bit oldTrig;
    imemValid = pendRet;
    imemData  = pendData;
    if (ackCnt > 0) begin
      ackCnt--;
      if (ackCnt == 0) ackIn = ~ackIn;
    end
    #1;
    reqNow = (hist.size() >= 1) && enable && !branchValid && !mOut && (mQ.size() < DEPTH);
    chk("imemReq", imemReq, reqNow);
    if (reqNow) chk("imemAddr", imemAddr, mPc);
    chk("readyOut", readyOut, mReady);
    chk("dataOut", dataOut, mData);
    chk("triggerOut", triggerOut, mTrig);
    if (imemReq) reqLog.push_back(imemAddr);
    if (triggerOut != prevDutTrig) sentLog.push_back(dataOut);
    prevDutTrig = triggerOut;
    pendRet  = imemReq;
    pendData = imemAddr + MEM_OFS;

    edgeNow = modelAckEdge();
    oldTrig = mTrig;
    if (mPhase == 0) begin
      if (mQ.size() > 0 && !branchValid) begin
        mData = mQ.pop_front(); mReady = 1; mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (branchValid) begin mReady = 0; mPhase = 0; end
      else begin mTrig = ~mTrig; mPhase = 2; end
    end else if (edgeNow) begin
      mReady = 0; mPhase = 0;
    end
    if (imemValid && !mStale && !branchValid) mQ.push_back(imemData);
    if (branchValid) mQ.delete();
    if (imemValid) mStale = 0;
    else if (branchValid && mOut) mStale = 1;
    if (reqNow) mOut = 1;
    else if (imemValid) mOut = 0;
    if (branchValid) mPc = branchTarget & ~32'd3;
    else if (reqNow) mPc = mPc + 32'd4;
    hist.push_back(ackIn);
    if (mTrig != oldTrig && ackOn) ackCnt = ackDelay;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit found;
    ackOn = 1; ackDelay = 3;
    #2;
    doReset();

    // Three sequential words with a prompt ack.
    enable = 1;
    repeat (6) step();
    enable = 0;
    repeat (60) step();
    chk("s1 req count", reqLog.size(), 3);
    chk("s1 addr0", reqLog[0], 32'h0000_0000);
    chk("s1 addr1", reqLog[1], 32'h0000_0004);
    chk("s1 addr2", reqLog[2], 32'h0000_0008);
    chk("s1 toggles", sentLog.size(), 3);
    chk("s1 data0", sentLog[0], 32'hE000_0000);
    chk("s1 data1", sentLog[1], 32'hE000_0004);
    chk("s1 data2", sentLog[2], 32'hE000_0008);
    chk("s1 idle ready", readyOut, 0);

    // Backpressure: downstream never acknowledges.
    doReset();
    ackOn = 0; enable = 1;
    repeat (40) step();
    chk("s2 req count", reqLog.size(), 5);
    chk("s2 toggles", sentLog.size(), 1);
    chk("s2 ready held", readyOut, 1);
    chk("s2 held word", dataOut, 32'hE000_0000);
    chk("s2 model fifo", mQ.size(), 4);

    // Redirect with a request in flight and three words buffered.
    doReset();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (pendRet && mQ.size() == 3) found = 1;
    end
    chk("s3 reach state", found, 1);
    branchValid = 1; branchTarget = 32'h0000_0103;
    step();
    branchValid = 0;
    chk("s3 model fifo empty", mQ.size(), 0);
    n = reqLog.size();
    repeat (4) step();
    chk("s3 next addr", reqLog[n], 32'h0000_0100);

    // Redirect while a word is offered but not yet triggered.
    doReset();
    ackOn = 1; ackDelay = 3;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mPhase == 1) found = 1;
      else step();
    end
    chk("s4 reach setup", found, 1);
    branchValid = 1; branchTarget = 32'h0000_0200;
    step();
    branchValid = 0;
    chk("s4 ready dropped", readyOut, 0);
    chk("s4 no toggle", triggerOut, 0);
    repeat (40) step();
    chk("s4 first sent", sentLog[0], 32'hE000_0200);

    // Address wrap at the top of the address space.
    n = reqLog.size();
    branchValid = 1; branchTarget = 32'hFFFF_FFF8;
    step();
    branchValid = 0;
    repeat (20) step();
    chk("s5 wrap0", reqLog[n], 32'hFFFF_FFF8);
    chk("s5 wrap1", reqLog[n+1], 32'hFFFF_FFFC);
    chk("s5 wrap2", reqLog[n+2], 32'h0000_0000);

    // Reset during WAIT_ACK with ackIn high.
    doReset();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mPhase == 2 && ackIn == 1'b1 && ackCnt >= 2) found = 1;
      else step();
    end
    chk("s6 reach wait", found, 1);
    doReset();
    chk("s6 ack level kept", ackIn, 1);
    repeat (40) step();
    chk("s6 first sent", sentLog[0], 32'hE000_0000);
    chk("s6 second sent", sentLog[1], 32'hE000_0004);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom % 8) != 0;
      branchValid  = ($urandom % 40) == 0;
      branchTarget = $urandom;
      ackDelay     = int'($urandom_range(6, 1));
      if (($urandom % 700) == 0) doReset();
      step();
    end
    branchValid = 0;
    enable = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
